// File: rtl/hpi_bus_engine.sv
// Cycle-level HPI bus master for the CY7C67300: one request in, strobed nCS/nRD/nWR pin cycle out, one-cycle response.
// Latency: rsp_valid SETUP+STROBE+HOLD+1 cycles after accept; next accept SETUP+STROBE+HOLD+TURN+1 cycles after accept.
// Backpressure: req_ready is low from the accept edge until the engine is back in IDLE; requests seen while busy are ignored.
module hpi_bus_engine #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        hpi_csn,
  output logic        hpi_oen,
  output logic        hpi_wen,
  output logic [1:0]  hpi_address,
  inout  wire  [15:0] hpi_data,
  input  logic        hpi_irq,
  output logic        irq_pending,
  input  logic        irq_ack
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  // Counter reload values: each phase lasts <param> cycles, counting down to zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        wr_q;
  logic        wr_eff;
  logic        busy_nxt;
  logic        data_oe;
  logic [15:0] data_q;
  logic        irq_s1, irq_s2, irq_s3;
  logic        irq_rise;

  // The data pins are only ever driven by the latched write data during a write's chip-select window.
  assign hpi_data = data_oe ? data_q : 16'bz;

  // Direction of the transfer in flight, including the one being accepted this cycle.
  assign wr_eff   = accept ? req_write : wr_q;
  assign busy_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD);

  // State and phase counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: each phase reloads the counter on entry and advances when it reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (cnt != 4'd0) begin
      cnt_nxt = cnt - 4'd1;
    end
    unique case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RECOVER;
          cnt_nxt   = TURN_LD;
        end
      end
      ST_RECOVER: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Pin and handshake registers, computed from the next state so every output is a flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      hpi_csn     <= 1'b1;
      hpi_oen     <= 1'b1;
      hpi_wen     <= 1'b1;
      hpi_address <= 2'd0;
      data_oe     <= 1'b0;
      data_q      <= 16'd0;
      wr_q        <= 1'b0;
    end else begin
      if (accept) begin
        wr_q        <= req_write;
        hpi_address <= req_addr;
        data_q      <= req_wdata;
      end
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state == ST_HOLD) && (state_nxt == ST_RECOVER);
      hpi_csn   <= !busy_nxt;
      hpi_oen   <= !((state_nxt == ST_STROBE) && !wr_eff);
      hpi_wen   <= !((state_nxt == ST_STROBE) && wr_eff);
      data_oe   <= busy_nxt && wr_eff;
    end
  end

  // Read data is sampled on the edge that ends the last strobe cycle, while nRD is still low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_rdata <= 16'd0;
    end else if ((state == ST_STROBE) && (cnt == 4'd0) && !wr_q) begin
      rsp_rdata <= hpi_data;
    end
  end

  assign irq_rise = irq_s2 && !irq_s3;

  // INT synchroniser and edge detector; a new edge wins over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_s1      <= 1'b0;
      irq_s2      <= 1'b0;
      irq_s3      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_s1 <= hpi_irq;
      irq_s2 <= irq_s1;
      irq_s3 <= irq_s2;
      if (irq_rise) begin
        irq_pending <= 1'b1;
      end else if (irq_ack) begin
        irq_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpi_bus_engine.sv
// Bench for hpi_bus_engine: a default-timing instance and a 2/5/3/2 instance share clock and reset.
// Latency: expected pin waveforms are derived per cycle from the phase lengths.
// Backpressure: req_valid is left high while busy with scrambled fields to confirm they are ignored.
module tb_hpi_bus_engine;

  typedef struct {
    int          inst;
    bit          w;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] rv;
    bit          keep;
    logic [15:0] exp_rd;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        hpi_csn   [2];
  logic        hpi_oen   [2];
  logic        hpi_wen   [2];
  logic [1:0]  hpi_address [2];
  logic        irq_pending [2];
  logic [15:0] rd_val [2];
  logic [15:0] bus_obs [2];
  logic [15:0] mdl [2];
  logic        hpi_irq0, irq_ack0, hpi_irq1, irq_ack1;
  wire  [15:0] hpi_data0, hpi_data1;

  int checks = 0;
  int errors = 0;

  // The bench plays the CY7C67300 side: it drives read data only while nRD is low.
  assign hpi_data0 = hpi_oen[0] ? 16'bz : rd_val[0];
  assign hpi_data1 = hpi_oen[1] ? 16'bz : rd_val[1];
  assign bus_obs[0] = hpi_data0;
  assign bus_obs[1] = hpi_data1;

  hpi_bus_engine dut0 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .hpi_csn(hpi_csn[0]), .hpi_oen(hpi_oen[0]), .hpi_wen(hpi_wen[0]),
    .hpi_address(hpi_address[0]), .hpi_data(hpi_data0),
    .hpi_irq(hpi_irq0), .irq_pending(irq_pending[0]), .irq_ack(irq_ack0)
  );

  hpi_bus_engine #(.SETUP_CYC(2), .STROBE_CYC(5), .HOLD_CYC(3), .TURN_CYC(2)) dut1 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .hpi_csn(hpi_csn[1]), .hpi_oen(hpi_oen[1]), .hpi_wen(hpi_wen[1]),
    .hpi_address(hpi_address[1]), .hpi_data(hpi_data1),
    .hpi_irq(hpi_irq1), .irq_pending(irq_pending[1]), .irq_ack(irq_ack1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // A released bus reads as z on a four-state simulator and as zero on a two-state one.
  function automatic bit released_ok(logic [15:0] v);
    return (v === 16'bz) || (v === 16'h0000);
  endfunction

  task automatic check_released(string name, logic [15:0] v);
    checks++;
    if (!released_ok(v)) begin
      errors++;
      $display("FAIL %s: bus=%h, required released", name, v);
    end
  endtask

  function automatic logic [31:0] ctl(int i);
    return {27'd0, hpi_csn[i], hpi_oen[i], hpi_wen[i], rsp_valid[i], req_ready[i]};
  endfunction

  task automatic check_reset_state(int i, string tag);
    check($sformatf("%s_ctl_i%0d", tag, i), ctl(i), 32'b11100);
    check($sformatf("%s_addr_i%0d", tag, i), {30'd0, hpi_address[i]}, 32'd0);
    check($sformatf("%s_rdata_i%0d", tag, i), {16'd0, rsp_rdata[i]}, 32'd0);
    check($sformatf("%s_irq_i%0d", tag, i), {31'd0, irq_pending[i]}, 32'd0);
    check_released($sformatf("%s_bus_i%0d", tag, i), bus_obs[i]);
  endtask

  // Issue one request at a negedge and check every cycle from accept until the engine is idle again.
  task automatic do_txn(int i, bit w, logic [1:0] a, logic [15:0] d, logic [15:0] rv, bit keep,
                        logic [15:0] exp_rd);
    int n, s, st, h, t, tot, rspk;
    bit in_cs, in_st;
    logic [4:0] exp_ctl;
    s  = (i == 0) ? 1 : 2;
    st = (i == 0) ? 3 : 5;
    h  = (i == 0) ? 1 : 3;
    t  = (i == 0) ? 1 : 2;
    tot  = s + st + h + t + 1;
    rspk = s + st + h + 1;
    rd_val[i]    = rv;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_i%0d: req_ready=%b, required 1", i, req_ready[i]);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_write[i] = ~w;
    req_addr[i]  = ~a;
    req_wdata[i] = ~d;
    for (int k = 1; k <= tot; k++) begin
      @(negedge clk);
      in_cs = (k >= 1) && (k <= s + st + h);
      in_st = (k >= s + 1) && (k <= s + st);
      exp_ctl = {!in_cs, !(!w && in_st), !(w && in_st), (k == rspk), (k == tot)};
      check($sformatf("ctl_i%0d_w%0d_k%0d", i, w, k), ctl(i), {27'd0, exp_ctl});
      if (in_cs) check($sformatf("addr_i%0d_k%0d", i, k), {30'd0, hpi_address[i]}, {30'd0, a});
      if (w && in_cs) check($sformatf("wdata_i%0d_k%0d", i, k), {16'd0, bus_obs[i]}, {16'd0, d});
      else if (!w && in_st) check($sformatf("rbus_i%0d_k%0d", i, k), {16'd0, bus_obs[i]}, {16'd0, rv});
      else check_released($sformatf("bus_i%0d_k%0d", i, k), bus_obs[i]);
      if (k == rspk) check($sformatf("rdata_i%0d", i), {16'd0, rsp_rdata[i]}, {16'd0, exp_rd});
    end
    if (!keep) req_valid[i] = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    int inst, nxt;
    bit w, keep;
    logic [1:0] a;
    logic [15:0] d, rv;

    vecs[0] = '{0, 1'b1, 2'd2, 16'h1000, 16'h0000, 1'b1, 16'h0000};
    vecs[1] = '{0, 1'b0, 2'd0, 16'h1357, 16'hBEEF, 1'b0, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 2'd1, 16'h1234, 16'h0000, 1'b1, 16'h0000};
    vecs[3] = '{1, 1'b0, 2'd3, 16'h2468, 16'hC0DE, 1'b1, 16'hC0DE};
    vecs[4] = '{1, 1'b1, 2'd0, 16'hABCD, 16'h0000, 1'b0, 16'hC0DE};
    vecs[5] = '{0, 1'b0, 2'd1, 16'h0F0F, 16'h0001, 1'b1, 16'h0001};
    vecs[6] = '{0, 1'b1, 2'd3, 16'h8001, 16'h0000, 1'b0, 16'h0001};
    vecs[7] = '{1, 1'b0, 2'd2, 16'h7777, 16'h8000, 1'b0, 16'h8000};

    resetn = 1'b1;
    hpi_irq0 = 1'b0; irq_ack0 = 1'b0; hpi_irq1 = 1'b0; irq_ack1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 2'd0;
      req_wdata[i] = 16'd0; rd_val[i] = 16'd0; mdl[i] = 16'd0;
    end
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state(0, "reset");
    check_reset_state(1, "reset");
    resetn = 1'b1;

    // Directed table, including back-to-back accepts with req_valid held high.
    for (int j = 0; j < 8; j++) begin
      do_txn(vecs[j].inst, vecs[j].w, vecs[j].a, vecs[j].d, vecs[j].rv, vecs[j].keep, vecs[j].exp_rd);
      if (!vecs[j].w) mdl[vecs[j].inst] = vecs[j].rv;
    end

    // Random traffic; rsp_rdata is modelled as the most recent read value per instance.
    nxt = int'($urandom_range(0, 1));
    for (int j = 0; j < 40; j++) begin
      inst = nxt;
      nxt  = int'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      a    = 2'($urandom_range(0, 3));
      d    = 16'($urandom_range(1, 16'hFFFF));
      rv   = 16'($urandom_range(1, 16'hFFFF));
      keep = (nxt == inst) && (j != 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!w) mdl[inst] = rv;
      do_txn(inst, w, a, d, rv, keep, mdl[inst]);
    end

    // Reset asserted in the middle of a write strobe.
    rd_val[0] = 16'h0000;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 2'd2; req_wdata[0] = 16'h4321;
    while (req_ready[0] !== 1'b1) @(negedge clk);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_strobe_wen", {31'd0, hpi_wen[0]}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    check_reset_state(0, "midrst");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("midrst_hold_k%0d", k), ctl(0), 32'b11100);
    end
    resetn = 1'b1;
    mdl[0] = 16'd0;
    mdl[1] = 16'd0;
    @(negedge clk);
    check("postrst_ready", {31'd0, req_ready[0]}, 32'd1);
    do_txn(0, 1'b0, 2'd0, 16'h1111, 16'h5A5A, 1'b0, 16'h5A5A);

    // Interrupt: synchroniser latency, single set per level, ack/edge priority.
    hpi_irq0 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("irq_rise_k%0d", k), {31'd0, irq_pending[0]}, {31'd0, (k >= 3)});
    end
    irq_ack0 = 1'b1;
    @(negedge clk);
    irq_ack0 = 1'b0;
    check("irq_ack_clear", {31'd0, irq_pending[0]}, 32'd0);
    repeat (5) @(negedge clk);
    check("irq_level_once", {31'd0, irq_pending[0]}, 32'd0);
    hpi_irq0 = 1'b0;
    repeat (5) @(negedge clk);
    hpi_irq0 = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_pre_edge", {31'd0, irq_pending[0]}, 32'd0);
    irq_ack0 = 1'b1;
    @(negedge clk);
    irq_ack0 = 1'b0;
    check("irq_edge_beats_ack", {31'd0, irq_pending[0]}, 32'd1);
    @(negedge clk);
    check("irq_sticky", {31'd0, irq_pending[0]}, 32'd1);
    irq_ack0 = 1'b1;
    @(negedge clk);
    irq_ack0 = 1'b0;
    check("irq_ack_clear2", {31'd0, irq_pending[0]}, 32'd0);
    check("irq_other_inst", {31'd0, irq_pending[1]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
